// File: rtl/alu_exec_if.sv
// alu_exec_if
//   Handshake and data bundle between an ALU-control producer and the
//   alu_exec execution unit.
//   Ports (signals):
//     in_valid      producer -> alu   command/operands valid
//     in_ready      alu -> producer   alu can take a command this cycle
//     ctrl_command  producer -> alu   4-bit operation code
//     operand_a/b   producer -> alu   WIDTH-bit operands
//     out_valid     alu -> producer   one-cycle pulse, result/flags updated
//     result        alu -> producer   WIDTH-bit result, held between pulses
//     zero          alu -> producer   result == 0
//     overflow      alu -> producer   arithmetic overflow flag
//     busy          alu -> producer   multiply in progress
//   Modports: master (producer side), slave (alu side).
interface alu_exec_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ctrl_command;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;
   logic             busy;

   modport master (
      output in_valid, ctrl_command, operand_a, operand_b,
      input  in_ready, out_valid, result, zero, overflow, busy
   );

   modport slave (
      input  in_valid, ctrl_command, operand_a, operand_b,
      output in_ready, out_valid, result, zero, overflow, busy
   );
endinterface

// File: rtl/alu_exec.sv
// alu_exec
//   Execution ALU. ADD/SUB/AND/OR (and unknown codes, executed as ADD)
//   finish in one cycle; MUL is an iterative shift-add multiplier taking
//   WIDTH iterations, during which in_ready is low.
//   Ports:
//     clk   single clock, all state on posedge
//     rst   synchronous active-high reset
//     bus   alu_exec_if slave modport (handshake, operands, result, flags)
module alu_exec #(
   parameter int         WIDTH  = 32,
   parameter logic [3:0] OP_ADD = 4'd0,
   parameter logic [3:0] OP_SUB = 4'd1,
   parameter logic [3:0] OP_MUL = 4'd2,
   parameter logic [3:0] OP_AND = 4'd3,
   parameter logic [3:0] OP_OR  = 4'd4
) (
   input logic     clk,
   input logic     rst,
   alu_exec_if.slave bus
);
   localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t             state_reg, state_next;
   logic               in_ready_int;
   logic               busy_int;
   logic               accept;
   logic               mul_last;

   logic [2*WIDTH-1:0] acc_reg;
   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [CW-1:0]      cnt_reg;
   logic [2*WIDTH-1:0] acc_next;

   logic               out_valid_reg;
   logic [WIDTH-1:0]   result_reg;
   logic               zero_reg;
   logic               overflow_reg;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_ov;

   assign accept   = bus.in_valid & in_ready_int;
   assign mul_last = (state_reg == S_MUL) && (cnt_reg == LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (accept && bus.ctrl_command == OP_MUL) state_next = S_MUL;
         S_MUL:   if (mul_last) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready_int = 1'b0;
      busy_int     = 1'b0;
      case (state_reg)
         S_IDLE:  in_ready_int = 1'b1;
         S_MUL:   busy_int     = 1'b1;
         default: in_ready_int = 1'b1;
      endcase
   end

   // ---------------- single-cycle operations ----------------
   // Unknown codes fall through to ADD. MUL never reaches this path's
   // result registers because its accept is steered to the multiplier.
   always_comb begin
      alu_res = '0;
      alu_ov  = 1'b0;
      case (bus.ctrl_command)
         OP_SUB: begin
            alu_res = bus.operand_a - bus.operand_b;
            // Operands of differing sign whose result sign differs from a.
            alu_ov  = (bus.operand_a[WIDTH-1] != bus.operand_b[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != bus.operand_a[WIDTH-1]);
         end
         OP_AND: alu_res = bus.operand_a & bus.operand_b;
         OP_OR:  alu_res = bus.operand_a | bus.operand_b;
         default: begin
            alu_res = bus.operand_a + bus.operand_b;
            // Operands of equal sign whose result sign differs.
            alu_ov  = (bus.operand_a[WIDTH-1] == bus.operand_b[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != bus.operand_a[WIDTH-1]);
         end
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current
   // multiplier LSB is set.
   assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

   // ---------------- datapath and result registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg       <= '0;
         mcand_reg     <= '0;
         mplier_reg    <= '0;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         zero_reg      <= 1'b1;
         overflow_reg  <= 1'b0;
      end else begin
         out_valid_reg <= 1'b0;
         if (accept) begin
            if (bus.ctrl_command == OP_MUL) begin
               mcand_reg  <= {{WIDTH{1'b0}}, bus.operand_a};
               mplier_reg <= bus.operand_b;
               acc_reg    <= '0;
               cnt_reg    <= '0;
            end else begin
               result_reg    <= alu_res;
               zero_reg      <= (alu_res == '0);
               overflow_reg  <= alu_ov;
               out_valid_reg <= 1'b1;
            end
         end else if (state_reg == S_MUL) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            if (mul_last) begin
               // Final iteration: publish straight from the adder output so
               // the result lands on the same edge that frees in_ready.
               cnt_reg       <= '0;
               result_reg    <= acc_next[WIDTH-1:0];
               zero_reg      <= (acc_next[WIDTH-1:0] == '0);
               overflow_reg  <= |acc_next[2*WIDTH-1:WIDTH];
               out_valid_reg <= 1'b1;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.busy      = busy_int;
   assign bus.out_valid = out_valid_reg;
   assign bus.result    = result_reg;
   assign bus.zero      = zero_reg;
   assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   typedef struct {
      string      name;
      logic [31:0] res;
      logic        z;
      logic        ov;
      int          due;
   } exp_t;

   exp_t sb[$];

   alu_exec_if #(.WIDTH(W)) bus ();

   alu_exec #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Issue one command; holds it until in_ready, pushes the expectation and
   // returns right after the accepting edge with in_valid still high.
   task automatic send(input string nm, input logic [3:0] cmd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic eo,
                       input int lat);
      exp_t e;
      int   t;
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.ctrl_command = cmd;
      bus.operand_a    = a;
      bus.operand_b    = b;
      t = 0;
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout_%s actual=in_ready_low required=in_ready_high", nm);
         bus.in_valid = 1'b0;
         return;
      end
      e.name = nm; e.res = er; e.z = ez; e.ov = eo; e.due = cyc + lat;
      sb.push_back(e);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (bus.out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid actual=%h required=no_pulse", bus.result);
         end else begin
            e = sb.pop_front();
            $display("txn %s result=%h zero=%b overflow=%b cycle=%0d", e.name,
                     bus.result, bus.zero, bus.overflow, cyc);
            chk({e.name, "_result"}, bus.result, e.res);
            chk({e.name, "_zero"}, 32'(bus.zero), 32'(e.z));
            chk({e.name, "_overflow"}, 32'(bus.overflow), 32'(e.ov));
            chk({e.name, "_latency"}, cyc, e.due);
            chk({e.name, "_ready_with_valid"}, 32'(bus.in_ready), 32'd1);
         end
      end
   end

   initial begin
      int low;
      rst              = 1'b1;
      bus.in_valid     = 1'b0;
      bus.ctrl_command = 4'd0;
      bus.operand_a    = '0;
      bus.operand_b    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd1);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      rst = 1'b0;

      // Single-cycle arithmetic
      send("add_7_5",   4'd0, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0, 1);
      idle();
      send("sub_5_5",   4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1);
      send("sub_ovf",   4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1);
      send("add_wrap",  4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
      send("add_ovf",   4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1);
      idle();

      // Multiply with in_ready low-time measurement
      send("mul_3", 4'd2, 32'd3, 32'h0001_2345, 32'h0003_69CF, 1'b0, 1'b0, W + 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      low = 0;
      while (!bus.in_ready && low < 100) begin
         low++;
         @(negedge clk);
      end
      chk("mul_ready_low_cycles", low, W);
      send("mul_ovf", 4'd2, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b1, W + 1);
      idle();

      // Back-to-back AND then OR
      send("and_b2b", 4'd3, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 1);
      send("or_b2b",  4'd4, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1'b0, 1);
      idle();

      // ADD held while MUL busy: accepted only once in_ready returns
      send("mul_6_7", 4'd2, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, W + 1);
      send("add_after_mul", 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1);
      idle();
      repeat (3) @(negedge clk);

      // Reset at MUL iteration 10 abandons the multiply
      send("mul_abort", 4'd2, 32'h0001_2345, 32'd3, 32'h0003_69CF, 1'b0, 1'b0, W + 1);
      void'(sb.pop_back());
      idle();
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_result", bus.result, 32'd0);
      chk("abort_zero", 32'(bus.zero), 32'd1);
      repeat (W + 5) @(negedge clk);

      // Unknown code executes as ADD
      send("unknown_cmd7", 4'd7, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);
      idle();

      low = 0;
      while (sb.size() != 0 && low < 200) begin
         @(negedge clk);
         low++;
      end
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
